// File: rtl/cc_xor_arbiter.sv
// ---------------------------------------------------------------------------
// cc_xor_arbiter
//
// Two requesters share one bitwise-XOR datapath. A four-state FSM grants the
// datapath to one requester at a time. On a tie, the requester that was not
// served last wins. The granted operands are latched, so the result does not
// depend on what the requester drives after the grant.
//
// Ports
//   cc_xor_arbiter_CLOCK_50      : clock, rising edge
//   cc_xor_arbiter_RESET_InLow   : asynchronous active-low reset
//   cc_xor_arbiter_req0_In/req1_In : operation requests
//   cc_xor_arbiter_a0_In/b0_In   : requester 0 operands (DATAWIDTH)
//   cc_xor_arbiter_a1_In/b1_In   : requester 1 operands (DATAWIDTH)
//   cc_xor_arbiter_ack0_Out/ack1_Out : one-cycle completion pulses
//   cc_xor_arbiter_z_Out         : result of the last completed operation
//   cc_xor_arbiter_busy_Out      : high whenever the FSM is not idle
//   cc_xor_arbiter_owner_Out     : current or most recent datapath owner
//   cc_xor_arbiter_count_Out     : completed-operation counter (wraps)
//
// Timing: a request sampled in IDLE at edge N is acknowledged after edge N+2.
// The earliest next grant is at edge N+4.
// ---------------------------------------------------------------------------
module cc_xor_arbiter #(
   parameter int DATAWIDTH = 8,
   parameter int CNTWIDTH  = 8
) (
   input  logic                 cc_xor_arbiter_CLOCK_50,
   input  logic                 cc_xor_arbiter_RESET_InLow,
   input  logic                 cc_xor_arbiter_req0_In,
   input  logic [DATAWIDTH-1:0] cc_xor_arbiter_a0_In,
   input  logic [DATAWIDTH-1:0] cc_xor_arbiter_b0_In,
   input  logic                 cc_xor_arbiter_req1_In,
   input  logic [DATAWIDTH-1:0] cc_xor_arbiter_a1_In,
   input  logic [DATAWIDTH-1:0] cc_xor_arbiter_b1_In,
   output logic                 cc_xor_arbiter_ack0_Out,
   output logic                 cc_xor_arbiter_ack1_Out,
   output logic [DATAWIDTH-1:0] cc_xor_arbiter_z_Out,
   output logic                 cc_xor_arbiter_busy_Out,
   output logic                 cc_xor_arbiter_owner_Out,
   output logic [CNTWIDTH-1:0]  cc_xor_arbiter_count_Out
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXEC    = 2'd1,
      RESP    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t                state_q;
   logic [DATAWIDTH-1:0]  opa_q;
   logic [DATAWIDTH-1:0]  opb_q;
   logic [DATAWIDTH-1:0]  z_q;
   logic                  owner_q;
   logic                  last_q;
   logic                  ack0_q;
   logic                  ack1_q;
   logic [CNTWIDTH-1:0]   count_q;

   logic                  grant_valid_d;
   logic                  grant_idx_d;
   logic [DATAWIDTH-1:0]  opa_d;
   logic [DATAWIDTH-1:0]  opb_d;
   logic                  owner_req_d;
   logic [DATAWIDTH-1:0]  xor_res_d;

   // Grant selection. On a tie, the requester that was not served last wins.
   always_comb begin
      grant_valid_d = cc_xor_arbiter_req0_In | cc_xor_arbiter_req1_In;
      if (cc_xor_arbiter_req0_In && cc_xor_arbiter_req1_In) begin
         grant_idx_d = ~last_q;
      end else begin
         grant_idx_d = cc_xor_arbiter_req1_In;
      end
      opa_d       = grant_idx_d ? cc_xor_arbiter_a1_In : cc_xor_arbiter_a0_In;
      opb_d       = grant_idx_d ? cc_xor_arbiter_b1_In : cc_xor_arbiter_b0_In;
      owner_req_d = owner_q ? cc_xor_arbiter_req1_In : cc_xor_arbiter_req0_In;
      xor_res_d   = opa_q ^ opb_q;
   end

   always_ff @(posedge cc_xor_arbiter_CLOCK_50 or negedge cc_xor_arbiter_RESET_InLow) begin
      if (!cc_xor_arbiter_RESET_InLow) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         z_q     <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;   // requester 0 wins the first tie
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         count_q <= '0;
      end else begin
         // The acks are single-cycle pulses. Only RESP raises them.
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_valid_d) begin
                  opa_q   <= opa_d;
                  opb_q   <= opb_d;
                  owner_q <= grant_idx_d;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               z_q     <= xor_res_d;
               state_q <= RESP;
            end
            RESP: begin
               if (owner_q) begin
                  ack1_q <= 1'b1;
               end else begin
                  ack0_q <= 1'b1;
               end
               count_q <= count_q + CNTWIDTH'(1);
               state_q <= RELEASE;
            end
            RELEASE: begin
               // Hold the datapath until the owner withdraws its request.
               // This stops a held request from being served twice.
               if (!owner_req_d) begin
                  last_q  <= owner_q;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cc_xor_arbiter_ack0_Out  = ack0_q;
   assign cc_xor_arbiter_ack1_Out  = ack1_q;
   assign cc_xor_arbiter_z_Out     = z_q;
   assign cc_xor_arbiter_busy_Out  = (state_q != IDLE);
   assign cc_xor_arbiter_owner_Out = owner_q;
   assign cc_xor_arbiter_count_Out = count_q;

endmodule

// File: tb/tb_cc_xor_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cc_xor_arbiter
//
// This bench runs directed scenarios with literal expectations, followed by a
// randomized phase. The DUT outputs are compared every cycle against a
// behavioural model. The model is time-based: it counts edges since the grant.
// ---------------------------------------------------------------------------
module tb_cc_xor_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic       ack0, ack1, busy, owner;
   logic [7:0] z, count;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   cc_xor_arbiter #(.DATAWIDTH(8), .CNTWIDTH(8)) dut (
      .cc_xor_arbiter_CLOCK_50    (clk),
      .cc_xor_arbiter_RESET_InLow (rst_n),
      .cc_xor_arbiter_req0_In     (req0),
      .cc_xor_arbiter_a0_In       (a0),
      .cc_xor_arbiter_b0_In       (b0),
      .cc_xor_arbiter_req1_In     (req1),
      .cc_xor_arbiter_a1_In       (a1),
      .cc_xor_arbiter_b1_In       (b1),
      .cc_xor_arbiter_ack0_Out    (ack0),
      .cc_xor_arbiter_ack1_Out    (ack1),
      .cc_xor_arbiter_z_Out       (z),
      .cc_xor_arbiter_busy_Out    (busy),
      .cc_xor_arbiter_owner_Out   (owner),
      .cc_xor_arbiter_count_Out   (count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A transaction is in flight from its grant edge until its owner releases.
   // The age is the number of edges since the grant:
   //   age 1 -> result appears
   //   age 2 -> ack pulse and count increment
   //   age >= 3 -> release once the owner's request is low
   bit         m_inflight = 0;
   int         m_age      = 0;
   bit         m_own      = 0;
   bit         m_last     = 1;
   bit         m_g        = 0;
   logic [7:0] m_a = '0, m_b = '0, m_z = '0, m_cnt = '0;
   bit         m_ack0 = 0, m_ack1 = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_inflight = 0; m_age = 0; m_own = 0; m_last = 1;
         m_a = '0; m_b = '0; m_z = '0; m_cnt = '0;
         m_ack0 = 0; m_ack1 = 0;
      end else begin
         m_ack0 = 0;
         m_ack1 = 0;
         if (!m_inflight) begin
            if (req0 || req1) begin
               m_g        = (req0 && req1) ? !m_last : req1;
               m_own      = m_g;
               m_a        = m_g ? a1 : a0;
               m_b        = m_g ? b1 : b0;
               m_inflight = 1;
               m_age      = 0;
            end
         end else begin
            m_age++;
            if (m_age == 1) begin
               m_z = m_a ^ m_b;
            end else if (m_age == 2) begin
               if (m_own) m_ack1 = 1; else m_ack0 = 1;
               m_cnt = m_cnt + 8'd1;
            end else if ((m_own ? req1 : req0) == 1'b0) begin
               m_inflight = 0;
               m_last     = m_own;
            end
         end
      end
   end

   // Per-cycle comparison, sampled just after the falling edge.
   always @(negedge clk) begin
      #1;
      if (cmp_en) begin
         check("ack0",  ack0,  m_ack0);
         check("ack1",  ack1,  m_ack1);
         check("z",     z,     m_z);
         check("busy",  busy,  m_inflight);
         check("owner", owner, m_own);
         check("count", count, m_cnt);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      #1;
      check("rst_ack0",  ack0,  0);
      check("rst_ack1",  ack1,  0);
      check("rst_z",     z,     0);
      check("rst_busy",  busy,  0);
      check("rst_owner", owner, 0);
      check("rst_count", count, 0);
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
   endtask

   task automatic wait_ack(input bit which, input string name);
      bit got = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if ((which ? ack1 : ack0) === 1'b1) begin
            got = 1;
            break;
         end
      end
      check(name, got, 1);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      // Single request: A5 ^ 0F = AA.
      do_reset();
      @(negedge clk);
      req0 = 1'b1; a0 = 8'hA5; b0 = 8'h0F;
      wait_ack(0, "single_ack0");
      check("single_z",     z,     8'hAA);
      check("single_count", count, 1);
      check("single_ack1",  ack1,  0);
      req0 = 1'b0;

      // Tie after reset: requester 0 wins, then 1, then 0 again.
      do_reset();
      @(negedge clk);
      req0 = 1'b1; a0 = 8'h11; b0 = 8'h22;
      req1 = 1'b1; a1 = 8'hF0; b1 = 8'h0F;
      wait_ack(0, "tie_first_ack0");
      check("tie_first_z", z, 8'h33);
      req0 = 1'b0;
      @(negedge clk);
      req0 = 1'b1;
      wait_ack(1, "tie_second_ack1");
      check("tie_second_z", z, 8'hFF);
      req1 = 1'b0;
      @(negedge clk);
      req1 = 1'b1;
      wait_ack(0, "tie_third_ack0");
      check("tie_third_z", z, 8'h33);
      req0 = 1'b0; req1 = 1'b0;

      // Held request: no second ack while the owner keeps its request high.
      @(negedge clk);
      req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
      wait_ack(0, "held_ack0");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("held_busy", busy, 1);
         check("held_noack", ack0, 0);
      end
      req0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("held_released", busy, 0);

      // Operands change after the grant and must not reach the result.
      @(negedge clk);
      req0 = 1'b1; a0 = 8'hFF; b0 = 8'h00;
      @(negedge clk);
      a0 = 8'h00;
      wait_ack(0, "opchg_ack0");
      check("opchg_z", z, 8'hFF);
      req0 = 1'b0;

      // Reset asserted while the operation is in EXEC.
      do_reset();
      @(negedge clk);
      req0 = 1'b1; a0 = 8'h3C; b0 = 8'hC3;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rexec_busy",  busy,  0);
      check("rexec_ack0",  ack0,  0);
      check("rexec_z",     z,     0);
      check("rexec_count", count, 0);
      check("rexec_owner", owner, 0);
      req0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rexec_count_after", count, 0);
      check("rexec_busy_after",  busy,  0);

      // Count wrap after 256 completions.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         req0 = 1'b1;
         a0 = 8'($urandom);
         b0 = 8'($urandom);
         wait_ack(0, "wrap_ack0");
         req0 = 1'b0;
         if (i == 254) check("wrap_count_255", count, 8'hFF);
      end
      @(negedge clk);
      check("wrap_count_0", count, 8'h00);

      // Randomized phase. Requests, operands and rare resets are random.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
         req0 = ($urandom_range(0, 9) < 6);
         req1 = ($urandom_range(0, 9) < 6);
         a0 = 8'($urandom); b0 = 8'($urandom);
         a1 = 8'($urandom); b1 = 8'($urandom);
      end
      @(negedge clk);
      rst_n = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      repeat (8) @(negedge clk);
      #2;
      cmp_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cc_xor_arbiter.md
CC_XOR_ARBITER -- requirements
Module: cc_xor_arbiter

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CNTWIDTH, default 8, giving the completed-operation counter width in bits.
REQ-003 cc_xor_arbiter_CLOCK_50  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 cc_xor_arbiter_RESET_InLow  input  1  asynchronous, active-low reset.
REQ-005 cc_xor_arbiter_req0_In  input  1  operation request from requester 0.
REQ-006 cc_xor_arbiter_a0_In, cc_xor_arbiter_b0_In  input  DATAWIDTH each  operands of requester 0.
REQ-007 cc_xor_arbiter_req1_In  input  1  operation request from requester 1.
REQ-008 cc_xor_arbiter_a1_In, cc_xor_arbiter_b1_In  input  DATAWIDTH each  operands of requester 1.
REQ-009 cc_xor_arbiter_ack0_Out, cc_xor_arbiter_ack1_Out  output  1 each  one-cycle completion pulse to the owning requester.
REQ-010 cc_xor_arbiter_z_Out  output  DATAWIDTH  registered result of the last completed operation.
REQ-011 cc_xor_arbiter_busy_Out  output  1  high whenever the state is not IDLE.
REQ-012 cc_xor_arbiter_owner_Out  output  1  index of the requester that currently holds, or last held, the datapath.
REQ-013 cc_xor_arbiter_count_Out  output  CNTWIDTH  number of completed operations.

Function
REQ-014 The block SHALL share one internal DATAWIDTH-bit bitwise-XOR datapath between the two requesters.
REQ-015 The block SHALL implement an FSM with exactly four states: IDLE, EXEC, RESP, RELEASE.
REQ-016 In IDLE with no request asserted, the block SHALL remain in IDLE.
REQ-017 In IDLE with exactly one request asserted, the block SHALL grant that requester, latch its a/b into the operand registers, set owner, and go to EXEC.
REQ-018 In IDLE with both requests asserted, the block SHALL grant the requester other than the last-served one (round robin) and proceed as in REQ-017.
REQ-019 In EXEC, the block SHALL register z = a XOR b from the latched operands and go to RESP, regardless of the requester's req level.
REQ-020 In RESP, ack of the owner SHALL be high for exactly that one cycle, the other ack SHALL stay low, count SHALL increment, and the next state SHALL be RELEASE.
REQ-021 count SHALL wrap from 2^CNTWIDTH-1 to 0.
REQ-022 In RELEASE, the block SHALL stay until the owner's req is low, then update last-served to owner and return to IDLE.
REQ-023 Latency SHALL be: req sampled in IDLE at edge N, ack and valid z visible after edge N+2, and the earliest next grant at edge N+4.
REQ-024 Operands changing after the grant edge SHALL NOT affect the in-flight result.
REQ-025 A requester dropping req during EXEC SHALL NOT abort the operation; ack still pulses in RESP.
REQ-026 A non-owner's req SHALL be held pending, without ack, until the FSM returns to IDLE.
REQ-027 z SHALL hold its value until the next RESP.
REQ-028 busy SHALL equal (state != IDLE).

Reset
REQ-029 While RESET_InLow = 0, the block SHALL immediately force: state IDLE, ack0 = ack1 = 0, z = 0, busy = 0, owner = 0, count = 0, operand registers 0, last-served = 1 (requester 0 wins the first tie).
REQ-030 Reset asserted in any state, including mid-EXEC or RESP, SHALL discard the operation with no ack and no count increment.
REQ-031 After reset release, the first grant SHALL occur on the first rising edge that samples a request.

Verification
REQ-032 Single request: req0 = 1, a0 = 8'hA5, b0 = 8'h0F in IDLE -> ack0 pulses one cycle two edges later, z = 8'hAA, count = 1, ack1 stays 0.
REQ-033 Tie after reset: req0 = req1 = 1 held -> first ack0, then ack1, then ack0 again; z alternates between the two XOR results.
REQ-034 Held req: owner keeps req high 5 cycles after ack -> FSM stays in RELEASE, busy = 1, no second ack until req drops and is reasserted.
REQ-035 Operand change: a0 changed from 8'hFF to 8'h00 the cycle after grant with b0 = 8'h00 -> z = 8'hFF.
REQ-036 Reset in EXEC: RESET_InLow pulsed low during EXEC -> all outputs 0 asynchronously, no ack, count unchanged at 0.
REQ-037 Wrap: 256 completed operations with CNTWIDTH = 8 -> count returns to 8'h00.
